// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA project wrapper: CSR offsets, COMMAND and
// STATUS bit positions, data chunk geometry, sequencer states and a helper.
package rsa_pkg;

  localparam int CSR_ADDR_W = 12;
  localparam int MEM_W      = 1024;
  localparam int CHUNK_W    = 224;
  localparam int DATA_WORDS = 7;

  // Byte offsets of the register file.
  localparam logic [11:0] OFS_COMMAND = 12'h000;
  localparam logic [11:0] OFS_STATUS  = 12'h000;
  localparam logic [11:0] OFS_DATA1   = 12'h004;
  localparam logic [11:0] OFS_DATA2   = 12'h008;
  localparam logic [11:0] OFS_DATA3   = 12'h00c;
  localparam logic [11:0] OFS_DATA4   = 12'h010;
  localparam logic [11:0] OFS_DATA5   = 12'h014;
  localparam logic [11:0] OFS_DATA6   = 12'h018;
  localparam logic [11:0] OFS_DATA7   = 12'h01c;

  // Word index (addr[4:2]) of COMMAND/STATUS.
  localparam logic [2:0] CSR_CMD_IDX = 3'd0;

  // COMMAND fields.
  localparam int CMD_EN_BIT   = 0;
  localparam int CMD_LOAD_BIT = 1;
  localparam int CMD_SLOT_LSB = 2;
  localparam int CMD_SLOT_W   = 5;
  localparam int CMD_SEL_LSB  = 7;
  localparam int CMD_SEL_W    = 3;

  // STATUS fields.
  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 3;

  // Loading this slot marks the job as done.
  localparam logic [2:0] LAST_SLOT = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_READ,
    ST_COPY
  } seq_state_t;

  // Position of the lowest set bit (0 when nothing is set).
  function automatic logic [2:0] low_bit_pos(input logic [4:0] v);
    logic [2:0] pos;
    pos = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) pos = 3'(i);
    end
    return pos;
  endfunction

endpackage

// File: rtl/rsa_project_wrapper_if.sv
// AXI4-Lite CSR bus of the RSA project wrapper, with host (master) and
// register file (slave) views.
interface rsa_project_wrapper_if;
  import rsa_pkg::*;

  logic [CSR_ADDR_W-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [CSR_ADDR_W-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/rsa_dp_bram.sv
// True dual-port memory, one clock, byte-lane write enables, registered reads.
// Port A output has a synchronous clear. On a same-word write from both ports
// port B (internal) overrides every lane.
module rsa_dp_bram #(
  parameter int WORDS = 16,
  parameter int WIDTH = 1024,
  localparam int AW    = $clog2(WORDS),
  localparam int LANES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             a_en,
  input  logic             a_rst,
  input  logic [LANES-1:0] a_we,
  input  logic [AW-1:0]    a_addr,
  input  logic [WIDTH-1:0] a_din,
  output logic [WIDTH-1:0] a_dout,
  input  logic             b_en,
  input  logic [LANES-1:0] b_we,
  input  logic [AW-1:0]    b_addr,
  input  logic [WIDTH-1:0] b_din,
  output logic [WIDTH-1:0] b_dout
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] lane_mem [WORDS];
    logic [7:0] a_q;
    logic [7:0] b_q;

    // Host lane applied first, so a same-cycle internal write lands last.
    always_ff @(posedge clk) begin
      if (a_en && a_we[gi]) lane_mem[a_addr] <= a_din[8*gi +: 8];
      if (b_en && b_we[gi]) lane_mem[b_addr] <= b_din[8*gi +: 8];
    end

    // Registered reads (old data on a same-cycle write).
    always_ff @(posedge clk) begin
      if (a_rst)     a_q <= '0;
      else if (a_en) a_q <= lane_mem[a_addr];
      if (b_en)      b_q <= lane_mem[b_addr];
    end

    assign a_dout[8*gi +: 8] = a_q;
    assign b_dout[8*gi +: 8] = b_q;
  end

endmodule

// File: rtl/rsa_project_wrapper.sv
// Host-facing wrapper of the RSA accelerator: AXI4-Lite CSRs (COMMAND/STATUS
// and DATA1..DATA7), a dual-port 1024-bit memory shared with the host BRAM
// port, and a small sequencer moving 224-bit chunks between them.
// Optional feature: define RSA_READBACK_EN to enable memory-to-DATA readback.
// MEM_WORDS must be a power of two and at least 8 (slots 0..5 must exist).
module rsa_project_wrapper
  import rsa_pkg::*;
#(
  parameter int MEM_WORDS = 16
) (
  input  logic                clk,
  input  logic                resetn,
  output logic                leds,
  rsa_project_wrapper_if.slave csrs,
  input  logic                mem_clk,
  input  logic [16:0]         mem_addr,
  input  logic [MEM_W-1:0]    mem_din,
  output logic [MEM_W-1:0]    mem_dout,
  input  logic                mem_en,
  input  logic                mem_rst,
  input  logic [MEM_W/8-1:0]  mem_we
);

  localparam int AW = $clog2(MEM_WORDS);

  logic             aw_ready_reg, b_valid_reg, ar_ready_reg, r_valid_reg;
  logic [31:0]      r_data_reg;
  logic [31:0]      data_reg [DATA_WORDS];
  logic             done_reg, last_reg;
  seq_state_t       state_reg;
  logic             int_en_reg, int_we_reg;
  logic [AW-1:0]    int_addr_reg;
  logic [MEM_W-1:0] int_din, int_dout;

  logic                  wr_fire, rd_fire, cmd_fire, rb_req;
  logic [2:0]            wr_idx, rd_idx, slot_num, sel_num;
  logic [31:0]           wmask, wr_bits, status, rd_word;
  logic [DATA_WORDS-1:0] data_we;
  logic [CMD_SLOT_W-1:0] slot_bits;
  logic [CMD_SEL_W-1:0]  sel_bits;
  logic [AW-1:0]         slot_addr, sel_addr;
  logic [CHUNK_W-1:0]    chunk;

  assign wr_fire  = aw_ready_reg & csrs.awvalid & csrs.wvalid;
  assign rd_fire  = ar_ready_reg & csrs.arvalid;
  assign wr_idx   = csrs.awaddr[4:2];
  assign rd_idx   = csrs.araddr[4:2];
  assign cmd_fire = wr_fire && (wr_idx == CSR_CMD_IDX);

  for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
    assign wmask[8*gi +: 8] = {8{csrs.wstrb[gi]}};
  end
  assign wr_bits = csrs.wdata & wmask;

  for (genvar gi = 0; gi < DATA_WORDS; gi++) begin : g_data
    assign data_we[gi] = wr_fire && (wr_idx == 3'(gi + 1));
    assign chunk[CHUNK_W-1-32*gi -: 32] = data_reg[gi];
  end
  assign int_din = {{(MEM_W-CHUNK_W){1'b0}}, chunk};

  // COMMAND decode: one-hot slot / readback select, lowest set bit wins.
  assign slot_bits = wr_bits[CMD_SLOT_LSB +: CMD_SLOT_W];
  assign sel_bits  = wr_bits[CMD_SEL_LSB +: CMD_SEL_W];
  assign slot_num  = (|slot_bits) ? low_bit_pos(slot_bits) + 3'd1 : 3'd0;
  assign sel_num   = low_bit_pos({2'b00, sel_bits});
`ifdef RSA_READBACK_EN
  assign rb_req = |sel_bits;
`else
  assign rb_req = 1'b0;
`endif

  // Zero-extend decoded slot/select numbers to a memory word index.
  always_comb begin
    slot_addr      = '0;
    slot_addr[2:0] = slot_num;
    sel_addr       = '0;
    sel_addr[2:0]  = sel_num;
  end

  // STATUS word and the read-data mux.
  always_comb begin
    status                = '0;
    status[STAT_BUSY_BIT] = (state_reg != ST_IDLE);
    status[STAT_DONE_BIT] = done_reg;
    rd_word               = status;
    if (rd_idx != CSR_CMD_IDX) rd_word = data_reg[rd_idx - 3'd1];
  end

  // AXI4-Lite handshakes: single-cycle ready pulses, valids held until taken.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_ready_reg <= 1'b0;
      b_valid_reg  <= 1'b0;
      ar_ready_reg <= 1'b0;
      r_valid_reg  <= 1'b0;
      r_data_reg   <= '0;
    end else begin
      aw_ready_reg <= csrs.awvalid & csrs.wvalid & ~b_valid_reg & ~aw_ready_reg;
      if (wr_fire)          b_valid_reg <= 1'b1;
      else if (csrs.bready) b_valid_reg <= 1'b0;
      ar_ready_reg <= csrs.arvalid & ~r_valid_reg & ~ar_ready_reg;
      if (rd_fire) begin
        r_valid_reg <= 1'b1;
        r_data_reg  <= rd_word;
      end else if (csrs.rready) begin
        r_valid_reg <= 1'b0;
      end
    end
  end

  // DATA registers and the load/readback sequencer; readback copy lands after
  // host DATA writes so it wins on a shared cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DATA_WORDS; i++) data_reg[i] <= '0;
      state_reg    <= ST_IDLE;
      int_en_reg   <= 1'b0;
      int_we_reg   <= 1'b0;
      int_addr_reg <= '0;
      last_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      for (int i = 0; i < DATA_WORDS; i++) begin
        if (data_we[i]) data_reg[i] <= (data_reg[i] & ~wmask) | wr_bits;
      end
      case (state_reg)
        ST_IDLE: begin
          if (cmd_fire && wr_bits == '0 && |csrs.wstrb) begin
            done_reg <= 1'b0;
          end else if (cmd_fire && wr_bits[CMD_EN_BIT]) begin
            if (wr_bits[CMD_LOAD_BIT]) begin
              int_en_reg   <= 1'b1;
              int_we_reg   <= 1'b1;
              int_addr_reg <= slot_addr;
              last_reg     <= (slot_num == LAST_SLOT);
              state_reg    <= ST_LOAD;
            end else if (rb_req) begin
              int_en_reg   <= 1'b1;
              int_we_reg   <= 1'b0;
              int_addr_reg <= sel_addr;
              state_reg    <= ST_READ;
            end
          end
        end
        ST_LOAD: begin
          int_en_reg <= 1'b0;
          int_we_reg <= 1'b0;
          if (last_reg) done_reg <= 1'b1;
          state_reg  <= ST_IDLE;
        end
        ST_READ: begin
          int_en_reg <= 1'b0;
          state_reg  <= ST_COPY;
        end
        ST_COPY: begin
          for (int i = 0; i < DATA_WORDS; i++) begin
            data_reg[i] <= int_dout[CHUNK_W-1-32*i -: 32];
          end
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign csrs.awready = aw_ready_reg;
  assign csrs.wready  = aw_ready_reg;
  assign csrs.bvalid  = b_valid_reg;
  assign csrs.bresp   = 2'b00;
  assign csrs.arready = ar_ready_reg;
  assign csrs.rvalid  = r_valid_reg;
  assign csrs.rdata   = r_data_reg;
  assign csrs.rresp   = 2'b00;
  assign leds         = done_reg;

  rsa_dp_bram #(
    .WORDS (MEM_WORDS),
    .WIDTH (MEM_W)
  ) u_bram (
    .clk    (clk),
    .a_en   (mem_en),
    .a_rst  (mem_rst),
    .a_we   (mem_we),
    .a_addr (mem_addr[7+AW-1:7]),
    .a_din  (mem_din),
    .a_dout (mem_dout),
    .b_en   (int_en_reg),
    .b_we   ({(MEM_W/8){int_we_reg}}),
    .b_addr (int_addr_reg),
    .b_din  (int_din),
    .b_dout (int_dout)
  );

endmodule

// File: tb/tb_rsa_project_wrapper.sv
// Directed self-checking bench for rsa_project_wrapper.
module tb_rsa_project_wrapper;
  import rsa_pkg::*;

  logic               clk;
  logic               resetn;
  logic               leds;
  logic [16:0]        mem_addr;
  logic [MEM_W-1:0]   mem_din;
  logic [MEM_W-1:0]   mem_dout;
  logic               mem_en;
  logic               mem_rst;
  logic [MEM_W/8-1:0] mem_we;

  rsa_project_wrapper_if bus();

  rsa_project_wrapper #(.MEM_WORDS(16)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .leds     (leds),
    .csrs     (bus),
    .mem_clk  (clk),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_en   (mem_en),
    .mem_rst  (mem_rst),
    .mem_we   (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_pass;
  logic [31:0]      d [7];
  logic [255:0]     chunk0;
  logic [255:0]     exp_slot [6];
  logic [MEM_W-1:0] clash;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [255:0] model_chunk();
    logic [255:0] c;
    c = '0;
    for (int i = 0; i < 7; i++) c[223-32*i -: 32] = d[i];
    return c;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [11:0] a, input logic [31:0] v, input logic [3:0] s,
                           input bit host_hit);
    int n;
    bus.awaddr = a; bus.wdata = v; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    while (bus.awready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("awready", 256'(bus.awready), 256'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    if (host_hit) begin
      mem_addr = 17'h00080; mem_din = clash; mem_we = '1; mem_en = 1'b1;
      @(posedge clk); #1;
      mem_en = 1'b0; mem_we = '0;
    end
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("bvalid", 256'(bus.bvalid), 256'd1);
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] v);
    int n;
    bus.araddr = a; bus.arvalid = 1'b1;
    n = 0;
    while (bus.arready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("arready", 256'(bus.arready), 256'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    n = 0;
    while (bus.rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    v = bus.rdata;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  task automatic write_data(input int i, input logic [31:0] v);
    axi_write(12'(4 * (i + 1)), v, 4'hf, 1'b0);
    d[i] = v;
  endtask

  task automatic mem_write(input logic [16:0] a, input logic [MEM_W-1:0] v);
    mem_addr = a; mem_din = v; mem_we = '1; mem_en = 1'b1;
    @(posedge clk); #1;
    mem_en = 1'b0; mem_we = '0;
  endtask

  task automatic mem_read(input logic [16:0] a, output logic [MEM_W-1:0] v);
    mem_addr = a; mem_we = '0; mem_en = 1'b1;
    @(posedge clk); #1;
    mem_en = 1'b0;
    v = mem_dout;
  endtask

  task automatic check_word(input string tag, input logic [16:0] a, input logic [255:0] exp);
    logic [MEM_W-1:0] w;
    mem_read(a, w);
    check(tag, 256'(w[223:0]), exp);
    check({tag, "_upper"}, 256'(|w[MEM_W-1:224]), 256'd0);
  endtask

  task automatic check_data_regs(input string tag);
    logic [31:0] r;
    for (int i = 0; i < 7; i++) begin
      axi_read(12'(4 * (i + 1)), r);
      check($sformatf("%s_d%0d", tag, i + 1), 256'(r), 256'(d[i]));
    end
  endtask

  logic [31:0]      r;
  logic [MEM_W-1:0] pat;
  logic [31:0]      first_vals [7];

  initial begin
    n_checks = 0; n_pass = 0;
    resetn = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    mem_addr = '0; mem_din = '0; mem_en = 1'b0; mem_rst = 1'b0; mem_we = '0;
    for (int i = 0; i < 7; i++) d[i] = '0;
    first_vals = '{32'h00000000, 32'h80000000, 32'h6e6f7071, 32'h6d6e6f70,
                   32'h6c6d6e6f, 32'h6b6c6d6e, 32'h6a6b6c6d};
    for (int i = 0; i < 32; i++) pat[32*i +: 32] = 32'hc0de0000 | 32'(i);
    clash = '1;

    // Reset state
    idle(3);
    check("rst_valids", 256'({bus.awready, bus.arready, bus.bvalid, bus.rvalid}), 256'd0);
    check("rst_leds", 256'(leds), 256'd0);
    resetn = 1'b1;
    idle(1);
    mem_rst = 1'b1;
    idle(1);
    mem_rst = 1'b0;
    check("mem_rst_dout", 256'(|mem_dout), 256'd0);
    axi_read(OFS_STATUS, r);
    check("rst_status", 256'(r), 256'd0);
    check("rresp", 256'(bus.rresp), 256'd0);

    // First load to slot 0
    for (int i = 0; i < 7; i++) write_data(i, first_vals[i]);
    check("bresp", 256'(bus.bresp), 256'd0);
    axi_write(OFS_COMMAND, 32'h3, 4'hf, 1'b0);
    idle(2);
    check_word("load0", 17'h00000,
               256'(224'h00000000_80000000_6e6f7071_6d6e6f70_6c6d6e6f_6b6c6d6e_6a6b6c6d));
    chunk0 = model_chunk();
    axi_read(OFS_DATA3, r);
    check("data3_rd", 256'(r), 256'h6e6f7071);

    // Slots 1..4 do not set done
    for (int k = 1; k <= 4; k++) begin
      write_data(0, 32'h10000000 + 32'(k));
      axi_write(OFS_COMMAND, 32'h3 | (32'h1 << (k + 1)), 4'hf, 1'b0);
      exp_slot[k] = model_chunk();
      idle(2);
      axi_read(OFS_STATUS, r);
      check($sformatf("status_slot%0d", k), 256'(r), 256'd0);
    end
    for (int k = 1; k <= 4; k++) begin
      check_word($sformatf("slot%0d", k), 17'(k * 128), exp_slot[k]);
    end

    // Slot 5 sets done
    write_data(0, 32'hdeadbeef);
    axi_write(OFS_COMMAND, 32'h43, 4'hf, 1'b0);
    exp_slot[5] = model_chunk();
    idle(2);
    axi_read(OFS_STATUS, r);
    check("status_done", 256'(r), 256'h8);
    check("leds_done", 256'(leds), 256'd1);
    check_word("slot5", 17'h00280, exp_slot[5]);

    // Enable bit clear: no action
    write_data(0, 32'h00000055);
    axi_write(OFS_COMMAND, 32'h2, 4'hf, 1'b0);
    idle(2);
    check_word("noop_word0", 17'h00000, chunk0);

    // Readback of host-written word 1
    mem_write(17'h00080, pat);
    axi_write(OFS_COMMAND, 32'h101, 4'hf, 1'b0);
    idle(4);
`ifdef RSA_READBACK_EN
    for (int i = 0; i < 7; i++) d[i] = pat[223-32*i -: 32];
`endif
    check_data_regs("rb1");
    axi_read(OFS_STATUS, r);
    check("status_after_rb", 256'(r), 256'h8);

    // Several select bits: lowest (word 0) wins
    axi_write(OFS_COMMAND, 32'h281, 4'hf, 1'b0);
    idle(4);
`ifdef RSA_READBACK_EN
    for (int i = 0; i < 7; i++) d[i] = chunk0[223-32*i -: 32];
`endif
    check_data_regs("rb_multi");

    // COMMAND = 0 clears done
    axi_write(OFS_COMMAND, 32'h0, 4'hf, 1'b0);
    idle(1);
    axi_read(OFS_STATUS, r);
    check("status_clear", 256'(r), 256'd0);
    check("leds_clear", 256'(leds), 256'd0);

    // Partial strobe to DATA3
    axi_write(OFS_DATA3, 32'h12345678, 4'b0011, 1'b0);
    d[2] = {d[2][31:16], 16'h5678};
    axi_read(OFS_DATA3, r);
    check("wstrb_data3", 256'(r), 256'(d[2]));

    // Host and internal write word 1 on the same edge: internal wins
    axi_write(OFS_COMMAND, 32'h7, 4'hf, 1'b1);
    idle(2);
    check_word("collision", 17'h00080, model_chunk());

    // Address aliasing and host index wrap
    axi_read(12'h024, r);
    check("alias_data1", 256'(r), 256'(d[0]));
    check_word("wrap", 17'h00880, model_chunk());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rsa_project_wrapper.md
# rsa_project_wrapper

Host-facing wrapper of the RSA accelerator project. It exposes an AXI4-Lite register file (command/status plus seven 32-bit data words) and an internal dual-port 1024-bit memory. It moves 224-bit data chunks between the registers and memory words, and reports completion through a status bit and a LED. It sits between the processing system's AXI-Lite bus and the BRAM port used by the testbench or DMA, and is the top level the arithmetic core attaches to.

## Interface
- MEM_WORDS, 16: depth of the internal 1024-bit memory, in words (power of two).
- clk  in  1  system clock; all logic runs on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- leds  out  1  mirrors status done bit.
- s_axi_csrs_awaddr/araddr  in  12  byte address; only bits [4:2] decoded.
- s_axi_csrs_awvalid/awready, wvalid/wready, bvalid/bready, arvalid/arready, rvalid/rready: standard AXI4-Lite handshakes, 1 bit each.
- s_axi_csrs_wdata  in  32; s_axi_csrs_wstrb  in  4; s_axi_csrs_rdata  out  32.
- s_axi_csrs_bresp/rresp  out  2  always 2'b00 (OKAY).
- mem_clk  in  1  must be tied to clk; unused internally.
- mem_addr  in  17  byte address; word index = mem_addr[7+log2(MEM_WORDS)-1:7]; upper bits ignored, so the index wraps.
- mem_din  in  1024; mem_dout  out  1024; mem_en  in  1; mem_rst  in  1 (synchronous clear of mem_dout); mem_we  in  128 (byte-lane enables).

## Operation
- Registers: offset 0 is write COMMAND / read STATUS. Offsets 4..28 are DATA1..DATA7, read/write. Writes honour wstrb per byte. Offset 32 and above alias by [4:2].
- COMMAND decode: bit1 = LOAD, bits[6:2] = load slot (one-hot, all zero = slot 0, bit k = slot k-1... precisely bit2→1, bit3→2, bit4→3, bit5→4, bit6→5), bits[9:7] = readback select (bit7→word 0, bit8→word 1, bit9→word 2), bit0 = enable. Commands with bit0 = 0 perform no action. COMMAND = 0 clears done.
- LOAD (bit0 & bit1): one cycle after the write is accepted, the internal port writes memory[slot] = {800'b0, DATA1..DATA7}, with DATA1 in bits [223:192] and DATA7 in [31:0]. Loading slot 5 sets done.
- READBACK (bit0, bit1 = 0, exactly one of bits[9:7]): memory[k] is read internally. Bits [223:0] are copied into DATA1..DATA7 two cycles after acceptance. Multiple select bits are treated as lowest-set-bit.
- LOAD and readback bits set together: LOAD only.
- STATUS: bit0 busy (internal access in flight), bit3 done, all others 0. Done persists until the COMMAND=0 write or reset.
- Host port: registered read; mem_dout = memory[index] one cycle after mem_en. Byte write when mem_en & mem_we[i].
- Same-word write collision: host lanes are applied first, then the internal write overrides all lanes.

## Timing
- Reset: all CSR registers 0, done 0, busy 0, every AXI valid/ready output 0, leds 0. mem_dout is 0 after mem_rst; memory contents are not reset.
- Write channel: awready and wready pulse high for one cycle when awvalid & wvalid & !bvalid. bvalid rises the next cycle and holds until bready.
- Read channel: arready pulses for one cycle when arvalid & !rvalid. rvalid with rdata follows the next cycle and holds until rready.
- A command write issued while busy is accepted, but its action is dropped. DATA writes during busy are allowed; readback updates win on the same cycle.
- Reset asserted mid-transaction aborts immediately; no memory write occurs after reset assertion.

## Configuration
- RSA_READBACK_EN defined: readback commands operate as above.
- RSA_READBACK_EN undefined: readback commands are no-ops, and busy is never set by them.

## Structure
- Shared package rsa_pkg: register offsets (COMMAND/STATUS=0, DATA1..7=4..28), COMMAND bit positions, STATUS bit positions (BUSY=0, DONE=3), the chunk width of 224.
- One sub-module: rsa_dp_bram. It is a true dual-port memory, 1024 bits × MEM_WORDS, with byte-enable write, registered read, and one clock.

## Test plan
- Reset, then read offset 0 -> 0x00000000; leds=0; bresp/rresp=0.
- Write DATA1..7 = 0, 0x80000000, 0x6e6f7071, 0x6d6e6f70, 0x6c6d6e6f, 0x6b6c6d6e, 0x6a6b6c6d, then COMMAND=0x3. Then host mem_read of addr 0 -> low 224 bits = 0x00000000_80000000_6e6f7071_..._6a6b6c6d and upper bits 0.
- Issue 0x7, 0xb, 0x13, 0x23 with differing data; STATUS bit3 stays 0. Then issue 0x43 -> STATUS reads 0x8 and leds=1.
- Host mem_write of addr 0x080 with all lanes, then COMMAND=0x101 -> DATA1..7 read back the low 224 bits of that word; with RSA_READBACK_EN undefined, DATA is unchanged.
- COMMAND=0 after done -> STATUS=0, leds=0.
- Write with wstrb=4'b0011 to DATA3 -> only the low 16 bits change. A simultaneous host/internal write to word 1 -> the internal data wins.
